// File: rtl/sram_pkg.sv
// Shared widths, default base address and FSM state encodings for the 16-bit SRAM controller.
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/sram_dq_iobuf.sv
// Tri-state buffer for the bidirectional SRAM data bus; keeps the inout handling out of the FSM.
module sram_dq_iobuf
    import sram_pkg::*;
(
    input  logic                   oe,
    input  logic [SRAM_DATA_W-1:0] dout,
    output logic [SRAM_DATA_W-1:0] din,
    inout  wire  [SRAM_DATA_W-1:0] dq
);

    assign dq  = oe ? dout : {SRAM_DATA_W{1'bz}};
    assign din = dq;

endmodule

// File: rtl/sram_controller.sv
// Splits one 32-bit word access into two 16-bit SRAM phases (low half, then high half).
// Optional one-entry last-read cache enabled by defining SRAM_CTRL_LAST_READ_CACHE_EN.
module sram_controller
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter int          PHASE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);

    localparam int CNT_W = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   is_write_q, is_write_d;
    logic [16:0]            word_q, word_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            read_data_q, read_data_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic                   we_n_q, we_n_d;
    logic                   dq_oe_q, dq_oe_d;
    logic [SRAM_DATA_W-1:0] dq_out_q, dq_out_d;
    logic [SRAM_DATA_W-1:0] dq_in;

    logic        request;
    logic [31:0] offset;
    logic [16:0] req_word;
    logic        unused_offset_bits;
    logic        cache_hit;
    logic [31:0] cache_data;

    assign request            = wr_en | rd_en;
    assign offset             = address - BASE_ADDR;
    assign req_word           = offset[18:2];
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
    logic        cache_valid_q, cache_valid_d;
    logic [16:0] cache_tag_q, cache_tag_d;
    logic [31:0] cache_data_q, cache_data_d;

    // Misses fill the entry once the full word is assembled; writes to the cached word keep it coherent.
    always_comb begin
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
        if (state_q == DONE) begin
            if (!is_write_q) begin
                cache_valid_d = 1'b1;
                cache_tag_d   = word_q;
                cache_data_d  = read_data_q;
            end else if (cache_valid_q && (cache_tag_q == word_q)) begin
                cache_data_d  = wdata_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= '0;
        end else begin
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_data_q  <= cache_data_d;
        end
    end

    assign cache_hit  = rd_en && !wr_en && cache_valid_q && (cache_tag_q == req_word);
    assign cache_data = cache_data_q;
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    // Pin values are computed for the state being entered so the registered pins line up with it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_write_d  = is_write_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        we_n_d      = we_n_q;
        dq_oe_d     = dq_oe_q;
        dq_out_d    = dq_out_q;
        case (state_q)
            IDLE: begin
                if (request) begin
                    is_write_d = wr_en;
                    word_d     = req_word;
                    wdata_d    = write_data;
                    cnt_d      = '0;
                    if (cache_hit) begin
                        state_d     = DONE;
                        read_data_d = cache_data;
                    end else begin
                        state_d     = LO;
                        sram_addr_d = {req_word, 1'b0};
                        we_n_d      = ~wr_en;
                        dq_oe_d     = wr_en;
                        dq_out_d    = write_data[15:0];
                    end
                end
            end
            LO: begin
                if (cnt_q == CNT_LAST) begin
                    if (!is_write_q) begin
                        read_data_d[15:0] = dq_in;
                    end
                    state_d     = HI;
                    cnt_d       = '0;
                    sram_addr_d = {word_q, 1'b1};
                    we_n_d      = ~is_write_q;
                    dq_oe_d     = is_write_q;
                    dq_out_d    = wdata_q[31:16];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HI: begin
                if (cnt_q == CNT_LAST) begin
                    if (!is_write_q) begin
                        read_data_d[31:16] = dq_in;
                    end
                    state_d     = DONE;
                    cnt_d       = '0;
                    sram_addr_d = '0;
                    we_n_d      = 1'b1;
                    dq_oe_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                sram_addr_d = '0;
                we_n_d      = 1'b1;
                dq_oe_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_write_q  <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_write_q  <= is_write_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
        end
    end

    sram_dq_iobuf u_dq_iobuf (
        .oe   (dq_oe_q),
        .dout (dq_out_q),
        .din  (dq_in),
        .dq   (SRAM_DQ)
    );

    assign ready     = ((state_q == IDLE) && !request) || (state_q == DONE);
    assign read_data = read_data_q;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: directed word accesses against a behavioural 16-bit SRAM.
module tb_sram_controller;
    import sram_pkg::*;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;

    int num_vectors = 0;
    int num_miscompares = 0;

    logic        model_drive;
    logic [15:0] mem [0:255];
    logic        cm_valid;
    logic [16:0] cm_tag;

    typedef struct {
        logic [31:0] rdata;
        int          low;
        int          we;
        logic [17:0] addr_lo;
        logic [17:0] addr_hi;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];

    sram_controller #(
        .BASE_ADDR    (32'd1024),
        .PHASE_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_UB_N  (ub_n),
        .SRAM_LB_N  (lb_n),
        .SRAM_WE_N  (we_n),
        .SRAM_CE_N  (ce_n),
        .SRAM_OE_N  (oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM: drives the bus only while reading, stores whatever is on the bus while WE_N is low.
    assign sram_dq = (model_drive && we_n && !oe_n && !ce_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!rst && !we_n && !ce_n) begin
            mem[sram_addr[7:0]] <= sram_dq;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_vectors++;
        if (actual !== expected) begin
            num_miscompares++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input string name, input logic wr, input logic rd,
                                  input logic [31:0] addr, input logic [31:0] data,
                                  input logic [31:0] exp_rd, input int exp_low, input int exp_we,
                                  input logic [17:0] alo, input logic [17:0] ahi);
        exp_t e;
        bit   done;
        e.rdata   = exp_rd;
        e.low     = exp_low;
        e.we      = exp_we;
        e.addr_lo = alo;
        e.addr_hi = ahi;
        sb.push_back(e);
        sb_name.push_back(name);
        @(posedge clk);
        #1;
        wr_en      = wr;
        rd_en      = rd;
        address    = addr;
        write_data = data;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ready) done = 1'b1;
        end
        if (!done) begin
            num_vectors++;
            num_miscompares++;
            $display("[TB] FAIL %s timeout: ready=0 after 40 cycles, expected 1", name);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Reads consult the bench's cache model: a hit is a one-cycle access with no SRAM activity.
    task automatic do_read(input string name, input logic [31:0] addr, input logic [31:0] exp_rd,
                           input logic [16:0] word, input logic [17:0] alo, input logic [17:0] ahi);
        logic hit;
`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
        hit = cm_valid && (cm_tag == word);
`else
        hit = 1'b0;
`endif
        cm_valid = 1'b1;
        cm_tag   = word;
        if (hit) apply_stimulus(name, 1'b0, 1'b1, addr, 32'h0, exp_rd, 1, 0, 18'd0, 18'd0);
        else     apply_stimulus(name, 1'b0, 1'b1, addr, 32'h0, exp_rd, 5, 0, alo, ahi);
    endtask

    // Monitor: measures each access and scores it against the queued expectation when ready rises.
    initial begin
        int          low_cnt;
        int          we_cnt;
        logic [17:0] cap_lo;
        logic [17:0] cap_hi;
        exp_t        e;
        string       n;
        low_cnt = 0;
        we_cnt  = 0;
        cap_lo  = '0;
        cap_hi  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                low_cnt = 0;
                we_cnt  = 0;
                cap_lo  = '0;
                cap_hi  = '0;
            end else begin
                if (!we_n) we_cnt++;
                if (!ready) begin
                    if (low_cnt == 1) cap_lo = sram_addr;
                    if (low_cnt == 3) cap_hi = sram_addr;
                    low_cnt++;
                end else if (low_cnt > 0) begin
                    if (sb.size() == 0) begin
                        num_vectors++;
                        num_miscompares++;
                        $display("[TB] FAIL unexpected_completion: got 1 completion, expected 0");
                    end else begin
                        e = sb.pop_front();
                        n = sb_name.pop_front();
                        check_output({n, " read_data"}, read_data, e.rdata);
                        check_output({n, " ready_low_cycles"}, low_cnt, e.low);
                        check_output({n, " we_low_cycles"}, we_cnt, e.we);
                        check_output({n, " addr_lo"}, {14'd0, cap_lo}, {14'd0, e.addr_lo});
                        check_output({n, " addr_hi"}, {14'd0, cap_hi}, {14'd0, e.addr_hi});
                    end
                    low_cnt = 0;
                    we_cnt  = 0;
                    cap_lo  = '0;
                    cap_hi  = '0;
                end
            end
        end
    end

    initial begin
        int   rises;
        logic prev;
        exp_t e;
        bit   hit2;
        rst         = 1'b1;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        address     = '0;
        write_data  = '0;
        model_drive = 1'b1;
        cm_valid    = 1'b0;
        cm_tag      = '0;

        repeat (2) @(negedge clk);
        check_output("reset ready", {31'd0, ready}, 32'd1);
        check_output("reset we_n", {31'd0, we_n}, 32'd1);
        check_output("reset sram_addr", {14'd0, sram_addr}, 32'd0);
        check_output("reset read_data", read_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        apply_stimulus("wr_1024", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0, 5, 4, 18'd0, 18'd1);
        check_output("mem[0]", {16'd0, mem[0]}, 32'h0000BEEF);
        check_output("mem[1]", {16'd0, mem[1]}, 32'h0000DEAD);

        do_read("rd_1024", 32'd1024, 32'hDEADBEEF, 17'd0, 18'd0, 18'd1);

        apply_stimulus("wr_1028", 1'b1, 1'b0, 32'd1028, 32'h12345678, 32'hDEADBEEF, 5, 4, 18'd2, 18'd3);
        do_read("rd_1028", 32'd1028, 32'h12345678, 17'd1, 18'd2, 18'd3);

        apply_stimulus("wrrd_1032", 1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 32'h12345678, 5, 4, 18'd4, 18'd5);
        check_output("mem[4]", {16'd0, mem[4]}, 32'h00005A5A);
        check_output("mem[5]", {16'd0, mem[5]}, 32'h0000A5A5);

        // Request held through DONE: the second read must restart from IDLE (word 0 via address 1027).
        e.rdata = 32'hDEADBEEF; e.we = 0; e.low = 5; e.addr_lo = 18'd0; e.addr_hi = 18'd1;
        sb.push_back(e);
        sb_name.push_back("b2b_first");
`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
        hit2 = 1'b1;
`else
        hit2 = 1'b0;
`endif
        e.low = hit2 ? 1 : 5;
        e.addr_hi = hit2 ? 18'd0 : 18'd1;
        sb.push_back(e);
        sb_name.push_back("b2b_second");
        cm_valid = 1'b1;
        cm_tag   = 17'd0;
        @(posedge clk);
        #1;
        rd_en   = 1'b1;
        address = 32'd1027;
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 80 && rises < 2; i++) begin
            @(negedge clk);
            if (ready && !prev) rises++;
            prev = ready;
        end
        if (rises < 2) begin
            num_vectors++;
            num_miscompares++;
            $display("[TB] FAIL b2b timeout: got %0d completions, expected 2", rises);
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;

        do_read("rd_1024_again", 32'd1024, 32'hDEADBEEF, 17'd0, 18'd0, 18'd1);
        apply_stimulus("wr_1024_badf00d", 1'b1, 1'b0, 32'd1024, 32'h0BADF00D, 32'hDEADBEEF, 5, 4, 18'd0, 18'd1);
        check_output("mem[0] after rewrite", {16'd0, mem[0]}, 32'h0000F00D);
        check_output("mem[1] after rewrite", {16'd0, mem[1]}, 32'h00000BAD);
        do_read("rd_1024_after_wr", 32'd1024, 32'h0BADF00D, 17'd0, 18'd0, 18'd1);

        // Abandon a write in its HI phase with an asynchronous reset.
        @(posedge clk);
        #1;
        wr_en      = 1'b1;
        address    = 32'd1040;
        write_data = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        check_output("hi_phase we_n", {31'd0, we_n}, 32'd0);
        check_output("hi_phase sram_addr", {14'd0, sram_addr}, 32'd9);
        model_drive = 1'b0;
        rst   = 1'b1;
        wr_en = 1'b0;
        #1;
        check_output("midreset ready", {31'd0, ready}, 32'd1);
        check_output("midreset we_n", {31'd0, we_n}, 32'd1);
        check_output("midreset sram_addr", {14'd0, sram_addr}, 32'd0);
        check_output("midreset read_data", read_data, 32'd0);
        check_output("midreset dq_oe", {31'd0, dut.u_dq_iobuf.oe}, 32'd0);
        @(negedge clk);
        #2;
        rst         = 1'b0;
        model_drive = 1'b1;
        cm_valid    = 1'b0;

        do_read("rd_1024_post_reset", 32'd1024, 32'h0BADF00D, 17'd0, 18'd0, 18'd1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            num_vectors++;
            num_miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Initiator side of the 16-bit asynchronous-pin SRAM interface. Sits between the ARM pipeline MEM stage and the external or simulated SRAM.
- Converts one 32-bit word read or write into two 16-bit SRAM accesses: low half first, then high half.
- Drives ready low while an access is in flight; the pipeline freezes on ~ready.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM half-word 0.
- PHASE_CYCLES, 2: cycles spent per half-word access; minimum 2 (address setup + data capture).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- wr_en  input  1  word write request from MEM stage.
- rd_en  input  1  word read request from MEM stage.
- address  input  32  byte address; bits [1:0] ignored.
- write_data  input  32  word to store.
- read_data  output  32  word returned by the last completed read.
- ready  output  1  high = no access pending / access complete; low = freeze pipeline.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  18  SRAM half-word address.
- SRAM_UB_N, SRAM_LB_N  output  1  byte enables; held 0.
- SRAM_WE_N  output  1  write strobe, active low.
- SRAM_CE_N, SRAM_OE_N  output  1  held 0.

Behaviour:
- Address map: offset = address - BASE_ADDR (32-bit, wraps modulo 2^32). word = offset[18:2]. SRAM_ADDR = {word[16:0], half}, where half = 0 for the low phase and 1 for the high phase.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE with wr_en|rd_en -> LO on the next edge; latch op, address and write_data.
  - LO stays PHASE_CYCLES cycles -> HI.
  - HI stays PHASE_CYCLES cycles -> DONE.
  - DONE -> IDLE unconditionally.
- Phase counter: 0..PHASE_CYCLES-1, cleared at each phase entry.
- ready = (IDLE && !(wr_en|rd_en)) || DONE, combinational. For a new request, ready is low for 1+2*PHASE_CYCLES cycles, then high for exactly one DONE cycle.
- Write phase:
  - SRAM_WE_N=0 for every cycle of the phase.
  - SRAM_DQ driven with write_data[15:0] in LO and write_data[31:16] in HI.
- Read phase:
  - SRAM_WE_N=1 and SRAM_DQ released to high-Z.
  - SRAM_DQ sampled on the edge ending the last phase cycle, into read_data[15:0] (LO) or read_data[31:16] (HI).
- SRAM_DQ is high-Z in IDLE, DONE and all read phases.
- All SRAM pin outputs are registered. In IDLE and DONE: SRAM_WE_N=1, SRAM_ADDR=0.
- Simultaneous wr_en and rd_en: treated as a write.
- Requests are sampled only in IDLE. A request asserted during DONE is ignored; the pipeline advances on that edge.
- Inputs must stay stable while ready=0; the controller uses its latched copies regardless.
- read_data holds its value until the next read's phase captures; writes do not alter it.
- Reset, asynchronous, any state: IDLE, counter 0, read_data=0, SRAM_WE_N=1, SRAM_ADDR=0, DQ high-Z. Any in-flight access is abandoned; a half-written word may remain in SRAM.

Optional Feature:
- Macro: SRAM_CTRL_LAST_READ_CACHE_EN.
- Defined:
  - One-entry cache: valid bit, 17-bit word tag, 32-bit data.
  - Read hitting a valid tag: IDLE -> DONE directly; ready low 1 cycle; read_data loaded from the entry; no SRAM pin activity.
  - Read miss fills the entry at DONE.
  - Write to the tagged word updates the entry data; write to another word leaves the entry unchanged.
  - Reset clears valid.
- Undefined: every read performs both SRAM phases; no cache storage is synthesised.

Decomposition:
- Shared package sram_pkg: state enum (IDLE, LO, HI, DONE), SRAM_ADDR_W=18, SRAM_DATA_W=16, default BASE_ADDR.
- Sub-module sram_dq_iobuf: 16-bit tri-state driver (oe, dout, din). Keeps the inout handling out of the FSM.

Test Plan:
- Bench SRAM model requirement: must release DQ whenever SRAM_WE_N=0.
- Reset mid-access: assert rst during the HI phase of a write -> immediately IDLE, SRAM_WE_N=1, DQ high-Z, read_data=0, ready=1.
- Write 0xDEADBEEF to 1024, PHASE_CYCLES=2:
  - SRAM[0]=0xBEEF, SRAM[1]=0xDEAD.
  - ready low 5 cycles, high 1 cycle.
  - SRAM_WE_N low exactly 4 cycles.
- Read 1024 after the above -> read_data=0xDEADBEEF at DONE. Read 1028 after writing 0x12345678 there -> SRAM_ADDR 2 then 3, read_data=0x12345678.
- wr_en=rd_en=1, address 1032, data 0xA5A55A5A -> treated as write; SRAM[4]=0x5A5A, SRAM[5]=0xA5A5; read_data unchanged.
- Requests held through DONE back-to-back -> second access starts only after IDLE is re-entered. Address 1027 -> same word as 1024 (low bits ignored).
- With SRAM_CTRL_LAST_READ_CACHE_EN:
  - Repeat read of 1024 -> ready low 1 cycle, no SRAM_ADDR change, data 0xDEADBEEF.
  - Write 0x0BADF00D to 1024, then read -> 0x0BADF00D.
